sha_stim: RTL

Stimulus stage that sits directly upstream of the SHA256 HLS-vs-VHDL comparison checker. It provides the free-running 30-bit cycle counter that the checker uses to timestamp digests. On each rising edge of the checker's trigger, it broadcasts one padded 512-bit message block to both SHA256 cores as sixteen 32-bit words. Both cores therefore start from the same stimulus, so any difference in their ready times reflects core latency only.

---
 rtl/sha_stim_pkg.sv | 34 +++
 rtl/sha_stim_bcast.sv | 38 +++
 rtl/sha_stim.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sha_stim_pkg.sv
// Shared types and constants for the SHA256 comparison stimulus stage.
// Holds the FSM state type, the "abc" message block words and the reference digest.
package sha_stim_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StStream,
        StDone
    } state_e;

    localparam int unsigned NWORDS = 16;
    localparam int unsigned IDX_W  = $clog2(NWORDS);

    localparam logic [31:0] W0    = 32'h61626380;
    localparam logic [31:0] WLAST = 32'h00000018;

    // SHA256("abc"); benches compare core digests against this
    localparam logic [255:0] EXP_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    // Single padded block: W0, then zero words, then the bit length
    function automatic logic [31:0] word_at(input logic [IDX_W-1:0] idx);
        logic [31:0] w;
        w = 32'h0;
        if (idx == IDX_W'(0)) begin
            w = W0;
        end else if (idx == IDX_W'(NWORDS - 1)) begin
            w = WLAST;
        end
        return w;
    endfunction

endpackage

// File: rtl/sha_stim_bcast.sv
// Dual-sink broadcast handshake: one pending flag (valid) per sink.
// o_advance fires on the edge where the last outstanding sink takes the current word.
module sha_stim_bcast (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_arm,
    input  logic i_clear,
    input  logic i_accept0,
    input  logic i_accept1,
    output logic o_valid0,
    output logic o_valid1,
    output logic o_advance
);

    logic r_valid0;
    logic r_valid1;

    assign o_valid0  = r_valid0;
    assign o_valid1  = r_valid1;
    assign o_advance = (r_valid0 | r_valid1)
                     & (~r_valid0 | i_accept0)
                     & (~r_valid1 | i_accept1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
        end else if (i_arm) begin
            r_valid0 <= 1'b1;
            r_valid1 <= 1'b1;
        end else begin
            // Each sink sees a word exactly once
            if (r_valid0 && i_accept0) r_valid0 <= 1'b0;
            if (r_valid1 && i_accept1) r_valid1 <= 1'b0;
        end
    end

endmodule

// File: rtl/sha_stim.sv
// Stimulus stage for the SHA256 HLS-vs-VHDL checker: free-running cycle counter plus
// one "abc" block broadcast to both cores on each accepted trigger rise.
module sha_stim #(
    parameter int unsigned CNT_W   = 30,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             triger_in,
    output logic [CNT_W-1:0] cnt_out,
    output logic [31:0]      msg_data,
    output logic             sha0_valid,
    input  logic             sha0_accept,
    output logic             sha1_valid,
    input  logic             sha1_accept,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic [15:0]      run_cnt
);
    import sha_stim_pkg::*;

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_trig_d;
    logic [IDX_W-1:0] r_idx;
    logic [TMO_W-1:0] r_tmo;
    logic [31:0]      r_msg;
    logic             r_done;
    logic             r_err;
    logic [15:0]      r_run;

    logic w_rise;
    logic w_last;
    logic w_expire;
    logic w_arm;
    logic w_advance;
    logic w_valid0;
    logic w_valid1;

    assign w_rise   = triger_in & ~r_trig_d;
    assign w_last   = (r_idx == IDX_W'(NWORDS - 1));
    // Completing the block on the final cycle takes priority over the abort
    assign w_expire = (r_state == StStream) && (r_tmo == TMO_W'(TIMEOUT - 1))
                      && !(w_advance && w_last);
    // Both valids low inside STREAM means the previous word is fully taken
    assign w_arm    = (r_state == StLoad)
                      || ((r_state == StStream) && !w_valid0 && !w_valid1 && !w_expire);

    sha_stim_bcast u_bcast (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_arm     (w_arm),
        .i_clear   (w_expire),
        .i_accept0 (sha0_accept),
        .i_accept1 (sha1_accept),
        .o_valid0  (w_valid0),
        .o_valid1  (w_valid1),
        .o_advance (w_advance)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_trig_d <= 1'b0;
            r_idx    <= '0;
            r_tmo    <= '0;
            r_msg    <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_run    <= '0;
        end else begin
            r_trig_d <= triger_in;
            r_done   <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_rise) r_state <= StLoad;
                end
                StLoad: begin
                    r_idx   <= '0;
                    r_msg   <= W0;
                    r_tmo   <= '0;
                    r_state <= StStream;
                end
                StStream: begin
                    r_tmo <= r_tmo + TMO_W'(1);
                    if (w_advance && w_last) begin
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else if (w_expire) begin
                        r_err   <= 1'b1;
                        r_state <= StIdle;
                    end else if (w_advance) begin
                        r_idx <= r_idx + IDX_W'(1);
                        r_msg <= word_at(r_idx + IDX_W'(1));
                    end
                end
                StDone: begin
                    r_run   <= r_run + 16'd1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign cnt_out     = r_cnt;
    assign msg_data    = r_msg;
    assign sha0_valid  = w_valid0;
    assign sha1_valid  = w_valid1;
    assign busy        = (r_state != StIdle);
    assign done        = r_done;
    assign err_timeout = r_err;
    assign run_cnt     = r_run;

endmodule
